// File: rtl/sti_pkg.sv
// Shared STI types: word length codes, deserializer FSM states, buffered word entry.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sti_pkg;

  // Widest word carried on the STI link; the transmitter sizes its shifter from this too.
  localparam int MAXW = 32;
  // Bit counter width: must hold MAXW+1 so an over-long burst is distinguishable.
  localparam int CNTW = 6;

  typedef enum logic [1:0] {
    LEN8  = 2'b00,
    LEN16 = 2'b01,
    LEN24 = 2'b10,
    LEN32 = 2'b11
  } len_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_PUSH = 2'b10
  } state_e;

  // One buffered word: error flag, reported length, right-aligned data.
  typedef struct packed {
    logic            err;
    logic [CNTW-1:0] len;
    logic [MAXW-1:0] data;
  } word_ent_t;

  // Expected bit count for a length code: 8 * (code + 1).
  function automatic logic [CNTW-1:0] len_bits(input len_code_e code);
    return ({4'b0000, code} + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/sti_word_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO, head entry visible combinationally from storage.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sti_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 39
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop frees the head slot before the push lands, so full+pop+push is legal.
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pop/push.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/sti_deserializer.sv
// STI serial receiver: rebuilds each valid-bit burst into a right-aligned word and queues it.
// Latency: last bit in cycle N, si_valid low in N+1, po_valid in N+2 when the buffer was empty.
// Backpressure: po_valid/po_ready; a word completing while the buffer is full is dropped and ovf_sticky set.
module sti_deserializer #(
  parameter int DEPTH = 2,
  parameter int MAXW  = sti_pkg::MAXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      cfg_length,
  input  logic            cfg_msb,
  input  logic            si_valid,
  input  logic            si_data,
  output logic            po_valid,
  input  logic            po_ready,
  output logic [MAXW-1:0] po_data,
  output logic [5:0]      po_len,
  output logic            po_err,
  output logic            ovf_sticky
);

  import sti_pkg::*;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(MAXW);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(MAXW + 1);

  state_e          r_state;
  state_e          w_next;
  logic            w_start;
  logic            w_store;
  logic            w_commit;
  logic [MAXW-1:0] r_word;
  logic [CNTW-1:0] r_cnt;
  len_code_e       r_len_code;
  logic            r_msb;
  word_ent_t       w_ent;
  word_ent_t       w_head;
  word_ent_t       r_hold;
  word_ent_t       w_out;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            r_ovf;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and datapath strobes. The word is committed on the edge that
  // enters PUSH; PUSH is the single gap cycle that may already start a new burst.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_store  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (si_valid) begin
          w_start = 1'b1;
          w_next  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (si_valid) begin
          w_store = 1'b1;
        end else begin
          w_commit = 1'b1;
          w_next   = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (si_valid) begin
          w_start = 1'b1;
          w_next  = ST_RECV;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift register, bit counter and per-burst config latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word     <= '0;
      r_cnt      <= '0;
      r_len_code <= LEN8;
      r_msb      <= 1'b0;
    end else if (w_start) begin
      r_len_code <= len_code_e'(cfg_length);
      r_msb      <= cfg_msb;
      r_cnt      <= 6'd1;
      r_word     <= MAXW'(si_data);
    end else if (w_store) begin
      // Bits past MAXW are discarded; the counter stops one above MAXW.
      if (r_cnt < CNT_FULL) begin
        if (r_msb) r_word <= {r_word[MAXW-2:0], si_data};
        else       r_word <= r_word | (MAXW'(si_data) << r_cnt);
      end
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 6'd1;
    end
  end

  // Entry built from the finished burst; saturated count reports as MAXW.
  always_comb begin
    w_ent      = '0;
    w_ent.data = r_word;
    w_ent.len  = (r_cnt > CNT_FULL) ? CNT_FULL : r_cnt;
    w_ent.err  = (r_cnt != len_bits(r_len_code));
  end

  assign w_pop = po_ready && !w_empty;

  sti_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(word_ent_t))
  ) u_fifo (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_push     (w_commit),
    .i_push_dat (w_ent),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head)
  );

  // Overflow flag: a commit into a full buffer with no pop loses that word.
  always_ff @(posedge clk) begin
    if (reset)                            r_ovf <= 1'b0;
    else if (w_commit && w_full && !w_pop) r_ovf <= 1'b1;
  end

  // Track the head so the outputs keep the last word once the buffer drains.
  always_ff @(posedge clk) begin
    if (reset)         r_hold <= '0;
    else if (!w_empty) r_hold <= w_head;
  end

  assign w_out      = w_empty ? r_hold : w_head;
  assign po_valid   = !w_empty;
  assign po_data    = w_out.data;
  assign po_len     = w_out.len;
  assign po_err     = w_out.err;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_sti_deserializer.sv
// Directed bench for sti_deserializer: bursts driven at negedge, outputs checked at negedge.
// Latency: checks the last-bit -> po_valid timing of N+2.
// Backpressure: exercises held words, overflow drop and in-order drain.
module tb_sti_deserializer;

  logic        clk;
  logic        reset;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        si_valid;
  logic        si_data;
  logic        po_valid;
  logic        po_ready;
  logic [31:0] po_data;
  logic [5:0]  po_len;
  logic        po_err;
  logic        ovf_sticky;

  int checks = 0;
  int errors = 0;

  sti_deserializer #(.DEPTH(2), .MAXW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .si_valid   (si_valid),
    .si_data    (si_data),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .po_data    (po_data),
    .po_len     (po_len),
    .po_err     (po_err),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n bits of w, one per cycle; MSB-first sends w[n-1] first.
  task automatic send_word(input logic [39:0] w, input int n, input logic msb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = msb ? w[n-1-i] : w[i];
    end
  endtask

  // One idle cycle after a burst (cycle N+1).
  task automatic end_burst();
    @(negedge clk);
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_length = 2'b00; cfg_msb = 1'b0;
    si_valid = 1'b0; si_data = 1'b0; po_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %0b want 0", po_valid); end
    checks++; if (po_data !== 32'h0)    begin errors++; $display("FAIL rst_data got %h want 00000000", po_data); end
    checks++; if (po_len !== 6'd0)      begin errors++; $display("FAIL rst_len got %0d want 0", po_len); end
    checks++; if (po_err !== 1'b0)      begin errors++; $display("FAIL rst_err got %0b want 0", po_err); end
    checks++; if (ovf_sticky !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %0b want 0", ovf_sticky); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb8();
    cfg_length = 2'b00; cfg_msb = 1'b1; po_ready = 1'b1;
    send_word(40'hB2, 8, 1'b1);
    end_burst();
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL msb8_early_valid got %0b want 0", po_valid); end
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)    begin errors++; $display("FAIL msb8_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'hB2)   begin errors++; $display("FAIL msb8_data got %h want 000000b2", po_data); end
    checks++; if (po_len !== 6'd8)      begin errors++; $display("FAIL msb8_len got %0d want 8", po_len); end
    checks++; if (po_err !== 1'b0)      begin errors++; $display("FAIL msb8_err got %0b want 0", po_err); end
    @(negedge clk);
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL msb8_one_cycle got %0b want 0", po_valid); end
    checks++; if (po_data !== 32'hB2)   begin errors++; $display("FAIL msb8_hold got %h want 000000b2", po_data); end
  endtask

  task automatic test_lsb16();
    cfg_length = 2'b01; cfg_msb = 1'b0; po_ready = 1'b1;
    send_word(40'hA5C3, 16, 1'b0);
    end_burst();
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)     begin errors++; $display("FAIL lsb16_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'hA5C3)  begin errors++; $display("FAIL lsb16_data got %h want 0000a5c3", po_data); end
    checks++; if (po_len !== 6'd16)      begin errors++; $display("FAIL lsb16_len got %0d want 16", po_len); end
    checks++; if (po_err !== 1'b0)       begin errors++; $display("FAIL lsb16_err got %0b want 0", po_err); end
    @(negedge clk);
  endtask

  task automatic test_len_err();
    cfg_length = 2'b10; cfg_msb = 1'b1; po_ready = 1'b1;
    send_word(40'hABCDE, 20, 1'b1);
    end_burst();
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)      begin errors++; $display("FAIL short_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'hABCDE)  begin errors++; $display("FAIL short_data got %h want 000abcde", po_data); end
    checks++; if (po_len !== 6'd20)       begin errors++; $display("FAIL short_len got %0d want 20", po_len); end
    checks++; if (po_err !== 1'b1)        begin errors++; $display("FAIL short_err got %0b want 1", po_err); end
    @(negedge clk);
    send_word(40'h123456, 24, 1'b1);
    end_burst();
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)       begin errors++; $display("FAIL w24_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'h123456)  begin errors++; $display("FAIL w24_data got %h want 00123456", po_data); end
    checks++; if (po_len !== 6'd24)        begin errors++; $display("FAIL w24_len got %0d want 24", po_len); end
    checks++; if (po_err !== 1'b0)         begin errors++; $display("FAIL w24_err got %0b want 0", po_err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cfg_length = 2'b11; cfg_msb = 1'b1; po_ready = 1'b0;
    send_word(40'hDEADBEEF, 32, 1'b1);
    end_burst();
    send_word(40'h12345678, 32, 1'b1);
    end_burst();
    checks++; if (ovf_sticky !== 1'b0)  begin errors++; $display("FAIL b2b_ovf_early got %0b want 0", ovf_sticky); end
    send_word(40'hCAFEF00D, 32, 1'b1);
    end_burst();
    repeat (3) @(negedge clk);
    checks++; if (po_valid !== 1'b1)       begin errors++; $display("FAIL b2b_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first got %h want deadbeef", po_data); end
    checks++; if (po_len !== 6'd32)        begin errors++; $display("FAIL b2b_len got %0d want 32", po_len); end
    checks++; if (po_err !== 1'b0)         begin errors++; $display("FAIL b2b_err got %0b want 0", po_err); end
    checks++; if (ovf_sticky !== 1'b1)     begin errors++; $display("FAIL b2b_ovf got %0b want 1", ovf_sticky); end
    po_ready = 1'b1;
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)       begin errors++; $display("FAIL b2b_second_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'h12345678) begin errors++; $display("FAIL b2b_second got %h want 12345678", po_data); end
    @(negedge clk);
    checks++; if (po_valid !== 1'b0)       begin errors++; $display("FAIL b2b_drained got %0b want 0", po_valid); end
    checks++; if (po_data !== 32'h12345678) begin errors++; $display("FAIL b2b_hold got %h want 12345678", po_data); end
    checks++; if (ovf_sticky !== 1'b1)     begin errors++; $display("FAIL b2b_ovf_held got %0b want 1", ovf_sticky); end
  endtask

  task automatic test_saturate();
    cfg_length = 2'b11; cfg_msb = 1'b1; po_ready = 1'b1;
    send_word(40'hFF_FFFF_FFFF, 40, 1'b1);
    end_burst();
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)        begin errors++; $display("FAIL sat_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat_data got %h want ffffffff", po_data); end
    checks++; if (po_len !== 6'd32)         begin errors++; $display("FAIL sat_len got %0d want 32", po_len); end
    checks++; if (po_err !== 1'b1)          begin errors++; $display("FAIL sat_err got %0b want 1", po_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    cfg_length = 2'b00; cfg_msb = 1'b1; po_ready = 1'b1;
    send_word(40'h15, 5, 1'b1);
    @(negedge clk);
    reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
    @(negedge clk);
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL mid_rst_valid got %0b want 0", po_valid); end
    checks++; if (po_data !== 32'h0)    begin errors++; $display("FAIL mid_rst_data got %h want 00000000", po_data); end
    checks++; if (po_len !== 6'd0)      begin errors++; $display("FAIL mid_rst_len got %0d want 0", po_len); end
    checks++; if (po_err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err got %0b want 0", po_err); end
    checks++; if (ovf_sticky !== 1'b0)  begin errors++; $display("FAIL mid_rst_ovf got %0b want 0", ovf_sticky); end
    @(negedge clk);
    reset = 1'b0;
    send_word(40'h3C, 8, 1'b1);
    end_burst();
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL post_rst_stale got %0b want 0", po_valid); end
    @(negedge clk);
    checks++; if (po_valid !== 1'b1)    begin errors++; $display("FAIL post_rst_valid got %0b want 1", po_valid); end
    checks++; if (po_data !== 32'h3C)   begin errors++; $display("FAIL post_rst_data got %h want 0000003c", po_data); end
    checks++; if (po_len !== 6'd8)      begin errors++; $display("FAIL post_rst_len got %0d want 8", po_len); end
    checks++; if (po_err !== 1'b0)      begin errors++; $display("FAIL post_rst_err got %0b want 0", po_err); end
    @(negedge clk);
    checks++; if (po_valid !== 1'b0)    begin errors++; $display("FAIL post_rst_extra got %0b want 0", po_valid); end
  endtask

  initial begin
    test_reset();
    test_msb8();
    test_lsb16();
    test_len_err();
    test_back_to_back();
    test_saturate();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
